// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one variable-latency memory port between fetch and execute.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module mem_port_arbiter #(
    parameter int ADDR_W         = `ADDRESS_SIZE,
    parameter int DATA_W         = `DATA_SIZE,
    parameter int MAX_EXEC_BURST = 4,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              exec_read,
    input  logic              exec_write,
    input  logic [ADDR_W-1:0] exec_address,
    input  logic [DATA_W-1:0] exec_data_in,
    output logic              exec_valid,
    output logic [DATA_W-1:0] exec_data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              error
);

    localparam logic [3:0] c_MAX_BURST    = 4'(MAX_EXEC_BURST);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY_FETCH = 2'd1,
        BUSY_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_burst_cnt;
    logic [7:0]  r_timer;

    logic        w_exec_pending;
    logic        w_fetch_pending;
    logic        w_grant_exec;
    logic        w_grant_fetch;

    // A requester still seeing its own valid pulse holds a stale level request.
    assign w_exec_pending  = (exec_read | exec_write) & ~exec_valid;
    assign w_fetch_pending = fetch_req & ~fetch_valid;

    assign w_grant_exec  = (r_state == IDLE) && w_exec_pending &&
                           (!fetch_req || (r_burst_cnt < c_MAX_BURST));
    assign w_grant_fetch = (r_state == IDLE) && !w_grant_exec && w_fetch_pending;

    assign stall = (exec_read | exec_write) & ~exec_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_burst_cnt   <= 4'd0;
            r_timer       <= 8'd0;
            fetch_valid   <= 1'b0;
            fetch_data    <= '0;
            exec_valid    <= 1'b0;
            exec_data_out <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_address   <= '0;
            mem_wdata     <= '0;
            error         <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            exec_valid  <= 1'b0;

            if (exec_read && exec_write) begin
                error <= 1'b1;
            end

            if (!fetch_req) begin
                r_burst_cnt <= 4'd0;
            end else if (w_grant_fetch) begin
                r_burst_cnt <= 4'd0;
            end else if (w_grant_exec && (r_burst_cnt != 4'hF)) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_grant_exec) begin
                        // Read and write together is performed as a write.
                        mem_req     <= 1'b1;
                        mem_we      <= exec_write;
                        mem_address <= exec_address;
                        if (exec_write) begin
                            mem_wdata <= exec_data_in;
                        end
                        r_timer <= 8'd0;
                        r_state <= BUSY_EXEC;
                    end else if (w_grant_fetch) begin
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_address <= fetch_address;
                        r_timer     <= 8'd0;
                        r_state     <= BUSY_FETCH;
                    end
                end

                BUSY_FETCH: begin
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        fetch_valid <= 1'b1;
                        fetch_data  <= mem_rdata;
                        r_state     <= IDLE;
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        mem_req     <= 1'b0;
                        fetch_valid <= 1'b1;
                        fetch_data  <= '0;
                        error       <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                BUSY_EXEC: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        exec_valid <= 1'b1;
                        if (!mem_we) begin
                            exec_data_out <= mem_rdata;
                        end
                        r_state <= IDLE;
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        // An aborted store leaves the load-data register untouched.
                        mem_req    <= 1'b0;
                        exec_valid <= 1'b1;
                        if (!mem_we) begin
                            exec_data_out <= '0;
                        end
                        error   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Directed scenarios plus randomized traffic against a reference model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_address = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          exec_read = 1'b0;
    logic          exec_write = 1'b0;
    logic [AW-1:0] exec_address = '0;
    logic [DW-1:0] exec_data_in = '0;
    logic          exec_valid;
    logic [DW-1:0] exec_data_out;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          error;

    int checks = 0;
    int passes = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_EXEC_BURST(MB), .MEM_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .exec_read(exec_read), .exec_write(exec_write),
        .exec_address(exec_address), .exec_data_in(exec_data_in),
        .exec_valid(exec_valid), .exec_data_out(exec_data_out),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .error(error)
    );

    always #5 clock = ~clock;

    // Reference model: owner 0 = none, 1 = fetch, 2 = exec.
    int            m_owner, m_waited, m_burst;
    logic          m_fv, m_ev, m_err, m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_fd, m_ed;

    task automatic model_reset();
        m_owner = 0; m_waited = 0; m_burst = 0;
        m_fv = 0; m_ev = 0; m_err = 0; m_req = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_fd = '0; m_ed = '0;
    endtask

    task automatic model_edge();
        bit pend_e, pend_f, take_e, done, aborted;
        pend_e = (exec_read || exec_write) && !m_ev;
        pend_f = fetch_req && !m_fv;
        m_fv = 0; m_ev = 0;
        if (exec_read && exec_write) m_err = 1;
        if (m_owner == 0) begin
            take_e = pend_e && (!fetch_req || m_burst < MB);
            if (take_e) begin
                m_owner = 2; m_req = 1; m_addr = exec_address; m_we = exec_write;
                if (exec_write) m_wdata = exec_data_in;
                m_waited = 0;
                if (fetch_req && m_burst < 15) m_burst++;
            end else if (pend_f) begin
                m_owner = 1; m_req = 1; m_addr = fetch_address; m_we = 0;
                m_waited = 0; m_burst = 0;
            end
        end else begin
            done = mem_ready; aborted = 0;
            if (!done) begin
                m_waited++;
                if (m_waited == TO) begin done = 1; aborted = 1; end
            end
            if (done) begin
                if (m_owner == 1) begin
                    m_fv = 1; m_fd = aborted ? '0 : mem_rdata;
                end else begin
                    m_ev = 1;
                    if (!m_we) m_ed = aborted ? '0 : mem_rdata;
                end
                if (aborted) m_err = 1;
                m_req = 0; m_owner = 0;
            end
        end
        if (!fetch_req) m_burst = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 0; fetch_req = 0; exec_read = 0; exec_write = 0; mem_ready = 0;
        fetch_address = '0; exec_address = '0; exec_data_in = '0; mem_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 0; fetch_req = 1; exec_read = 1; mem_ready = 1; mem_rdata = 16'hFFFF;
        repeat (2) @(negedge clock);
        checks++;
        if ({fetch_valid, exec_valid, mem_req, mem_we, error} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {fetch_valid, exec_valid, mem_req, mem_we, error});
        else passes++;
        checks++;
        if ({fetch_data, exec_data_out, mem_address, mem_wdata} !== 64'h0)
            $display("FAIL reset_data: got %h expected 0", {fetch_data, exec_data_out, mem_address, mem_wdata});
        else passes++;
        checks++;
        if (stall !== 1'b1) $display("FAIL reset_stall: got %b expected 1", stall);
        else passes++;
    endtask

    task automatic test_zero_wait_read();
        apply_reset();
        exec_read = 1; exec_address = 16'h0012; mem_ready = 1; mem_rdata = 16'hBEEF;
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL zw_stall_req: got %b expected 1", stall);
        else passes++;
        @(negedge clock);
        checks++;
        if ({mem_req, mem_we, mem_address, exec_valid} !== {1'b1, 1'b0, 16'h0012, 1'b0})
            $display("FAIL zw_grant: got %b_%b_%h_%b expected 1_0_0012_0", mem_req, mem_we, mem_address, exec_valid);
        else passes++;
        @(negedge clock);
        checks++;
        if ({mem_req, exec_valid, stall} !== 3'b010)
            $display("FAIL zw_done_ctrl: got %b expected 010", {mem_req, exec_valid, stall});
        else passes++;
        checks++;
        if (exec_data_out !== 16'hBEEF) $display("FAIL zw_data: got %h expected beef", exec_data_out);
        else passes++;
        exec_read = 0; mem_ready = 0;
        @(negedge clock);
        checks++;
        if ({mem_req, exec_valid} !== 2'b00) $display("FAIL zw_after: got %b expected 00", {mem_req, exec_valid});
        else passes++;
    endtask

    task automatic test_write_wait();
        apply_reset();
        exec_read = 1; exec_address = 16'h0001; mem_ready = 1; mem_rdata = 16'h5A5A;
        repeat (2) @(negedge clock);
        exec_read = 0; mem_ready = 0;
        @(negedge clock);
        exec_write = 1; exec_address = 16'h0030; exec_data_in = 16'h00A5; mem_rdata = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if ({mem_req, mem_we, mem_address, mem_wdata} !== {1'b1, 1'b1, 16'h0030, 16'h00A5})
                $display("FAIL wr_hold cycle %0d: got %b_%b_%h_%h expected 1_1_0030_00a5",
                         i, mem_req, mem_we, mem_address, mem_wdata);
            else passes++;
            if (i == 3) mem_ready = 1;
        end
        @(negedge clock);
        checks++;
        if ({mem_req, exec_valid} !== 2'b01) $display("FAIL wr_done: got %b expected 01", {mem_req, exec_valid});
        else passes++;
        checks++;
        if (exec_data_out !== 16'h5A5A) $display("FAIL wr_data_kept: got %h expected 5a5a", exec_data_out);
        else passes++;
        exec_write = 0; mem_ready = 0;
    endtask

    task automatic test_timeout();
        apply_reset();
        fetch_req = 1; fetch_address = 16'h0040; mem_ready = 1; mem_rdata = 16'h1234;
        repeat (2) @(negedge clock);
        checks++;
        if ({fetch_valid, fetch_data, error} !== {1'b1, 16'h1234, 1'b0})
            $display("FAIL to_first_fetch: got %b_%h_%b expected 1_1234_0", fetch_valid, fetch_data, error);
        else passes++;
        fetch_req = 0; mem_ready = 0;
        @(negedge clock);
        fetch_req = 1; fetch_address = 16'h0044;
        for (int i = 0; i < TO; i++) begin
            @(negedge clock);
            checks++;
            if (mem_req !== 1'b1) $display("FAIL to_req_held cycle %0d: got %b expected 1", i, mem_req);
            else passes++;
        end
        @(negedge clock);
        checks++;
        if ({mem_req, fetch_valid, fetch_data, error} !== {1'b0, 1'b1, 16'h0000, 1'b1})
            $display("FAIL to_abort: got %b_%b_%h_%b expected 0_1_0000_1", mem_req, fetch_valid, fetch_data, error);
        else passes++;
        fetch_req = 0;
        repeat (3) @(negedge clock);
        checks++;
        if ({error, fetch_valid} !== 2'b10) $display("FAIL to_sticky: got %b expected 10", {error, fetch_valid});
        else passes++;
    endtask

    task automatic test_illegal();
        apply_reset();
        exec_read = 1; exec_write = 1; exec_address = 16'h0055; exec_data_in = 16'h0077;
        #1;
        checks++;
        if (error !== 1'b0) $display("FAIL ill_pre_err: got %b expected 0", error);
        else passes++;
        @(negedge clock);
        checks++;
        if ({mem_req, mem_we, mem_wdata, error} !== {1'b1, 1'b1, 16'h0077, 1'b1})
            $display("FAIL ill_as_write: got %b_%b_%h_%b expected 1_1_0077_1", mem_req, mem_we, mem_wdata, error);
        else passes++;
        mem_ready = 1;
        @(negedge clock);
        checks++;
        if ({exec_valid, exec_data_out} !== {1'b1, 16'h0000})
            $display("FAIL ill_done: got %b_%h expected 1_0000", exec_valid, exec_data_out);
        else passes++;
        exec_read = 0; exec_write = 0; mem_ready = 0;
        @(negedge clock);
        checks++;
        if (error !== 1'b1) $display("FAIL ill_sticky: got %b expected 1", error);
        else passes++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        exec_read = 1; exec_write = 1; exec_address = 16'h0066;
        fetch_req = 1; fetch_address = 16'h0088;
        @(negedge clock);
        checks++;
        if ({mem_req, mem_we, error} !== 3'b111) $display("FAIL rm_busy: got %b expected 111", {mem_req, mem_we, error});
        else passes++;
        @(negedge clock);
        #2 reset = 0;
        #1;
        checks++;
        if ({mem_req, mem_we, exec_valid, fetch_valid, error, mem_address} !== 21'h0)
            $display("FAIL rm_async_clear: got %b_%b_%b_%b_%b_%h expected all 0",
                     mem_req, mem_we, exec_valid, fetch_valid, error, mem_address);
        else passes++;
        exec_read = 0; exec_write = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        checks++;
        if ({mem_req, mem_we, mem_address} !== {1'b1, 1'b0, 16'h0088})
            $display("FAIL rm_fetch_first: got %b_%b_%h expected 1_0_0088", mem_req, mem_we, mem_address);
        else passes++;
    endtask

    task automatic test_random();
        int p_req[4] = '{50, 100, 100, 30};
        int p_rdy[4] = '{60, 50, 100, 15};
        int sel;
        apply_reset();
        model_reset();
        for (int ph = 0; ph < 4; ph++) begin
            for (int cyc = 0; cyc < 800; cyc++) begin
                if (!fetch_req || m_fv) begin
                    fetch_req = ($urandom_range(99) < p_req[ph]);
                    fetch_address = AW'($urandom);
                end
                if (!(exec_read || exec_write) || m_ev) begin
                    exec_read = 0; exec_write = 0;
                    if ($urandom_range(99) < p_req[ph]) begin
                        sel = $urandom_range(99);
                        exec_read  = (sel < 47) || (sel >= 94);
                        exec_write = (sel >= 47);
                    end
                    exec_address = AW'($urandom);
                    exec_data_in = DW'($urandom);
                end
                mem_ready = ($urandom_range(99) < p_rdy[ph]);
                mem_rdata = DW'($urandom);
                @(posedge clock);
                model_edge();
                @(negedge clock);
                checks++;
                if ({fetch_valid, exec_valid, mem_req, mem_we, error} !== {m_fv, m_ev, m_req, m_we, m_err})
                    $display("FAIL rnd_ctrl ph%0d cyc%0d: got %b expected %b", ph, cyc,
                             {fetch_valid, exec_valid, mem_req, mem_we, error}, {m_fv, m_ev, m_req, m_we, m_err});
                else passes++;
                checks++;
                if ({mem_address, mem_wdata} !== {m_addr, m_wdata})
                    $display("FAIL rnd_mem ph%0d cyc%0d: got %h_%h expected %h_%h", ph, cyc,
                             mem_address, mem_wdata, m_addr, m_wdata);
                else passes++;
                checks++;
                if ({fetch_data, exec_data_out} !== {m_fd, m_ed})
                    $display("FAIL rnd_data ph%0d cyc%0d: got %h_%h expected %h_%h", ph, cyc,
                             fetch_data, exec_data_out, m_fd, m_ed);
                else passes++;
                checks++;
                if (stall !== ((exec_read || exec_write) && !m_ev))
                    $display("FAIL rnd_stall ph%0d cyc%0d: got %b expected %b", ph, cyc,
                             stall, ((exec_read || exec_write) && !m_ev));
                else passes++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
